// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encoding and port indices shared by the arbiter and its bench
package mem_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: two-port winner select; a held lock beats the round-robin pointer
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock,
  input  logic       lock_owner,
  output logic       win
);
  always_comb win = (lock && req[lock_owner]) ? lock_owner : (&req) ? ptr : req[PORT1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter with lock for a single-cycle shared memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  state_t state, state_nxt;
  logic [1:0] ack;
  logic ptr, owner, lock, win, grant, capture;
  rr_pick u_pick (.req({req1, req0}), .ptr(ptr), .lock(lock), .lock_owner(owner), .win(win));
  assign ack0 = ack[PORT0];
  assign ack1 = ack[PORT1];
  always_comb begin
    grant = (state == S_IDLE) && (req0 || req1);
    capture = (state == S_ACCESS) && !mem_we;
    state_nxt = (state == S_IDLE) ? (grant ? S_ACCESS : S_IDLE) : (state == S_ACCESS) ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  // lock is rewritten in every idle cycle, so an owner that skips its first idle slot loses it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      ack <= 2'b00;
      rdata0 <= '0;
      rdata1 <= '0;
      owner <= PORT0;
      ptr <= PORT0;
      lock <= 1'b0;
    end else begin
      mem_we <= grant & (win ? we1 : we0);
      ack <= (state == S_ACCESS) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      if (state == S_IDLE) lock <= grant & (win ? lock1 : lock0);
      if (grant) begin
        owner <= win;
        ptr <= ~win;
        mem_addr <= win ? addr1 : addr0;
        mem_wdata <= win ? wdata1 : wdata0;
      end
      if (capture && owner == PORT0) rdata0 <= mem_rdata;
      if (capture && owner == PORT1) rdata1 <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios checked against a transaction-level arbiter model
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  logic clk = 1'b0, reset;
  logic req0, req1, we0, we1, lock0, lock1, ack0, ack1, mem_we;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic [DW-1:0] mem [256];
  int tests = 0, fails = 0, cyc = 0, we_cycles = 0, wr_acks = 0;
  int n, p, lastc;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 'h85) ? 8'h3C : 8'(a ^ 'h5A);
  endfunction
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (reset) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (mem_we) mem[mem_addr] <= mem_wdata;

  // Model: a transaction passes through phase 1 (bus) and phase 2 (ack) before the next pick
  int m_phase, m_owner, m_last, m_lock, m_win;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic m_we;
  logic [DW-1:0] m_rd [2];

  function automatic int pick(input logic r0, input logic r1, input int last, input int lk);
    if (lk == 0 && r0) return 0;
    if (lk == 1 && r1) return 1;
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction
  assign m_win = pick(req0, req1, m_last, m_lock);

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_phase <= 0; m_owner <= 0; m_last <= 1; m_lock <= -1;
      m_addr <= '0; m_wdata <= '0; m_we <= 1'b0; m_rd[0] <= '0; m_rd[1] <= '0;
    end else if (m_phase == 0) begin
      if (req0 || req1) begin
        m_phase <= 1;
        m_owner <= m_win;
        m_last <= m_win;
        m_lock <= ((m_win == 1) ? lock1 : lock0) ? m_win : -1;
        m_addr <= (m_win == 1) ? addr1 : addr0;
        m_wdata <= (m_win == 1) ? wdata1 : wdata0;
        m_we <= (m_win == 1) ? we1 : we0;
      end else m_lock <= -1;
    end else if (m_phase == 1) begin
      if (!m_we) m_rd[m_owner] <= mem[m_addr];
      m_phase <= 2;
    end else m_phase <= 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ack0", ack0, m_phase == 2 && m_owner == 0);
    chk("ack1", ack1, m_phase == 2 && m_owner == 1);
    chk("one_ack", ack0 & ack1, 0);
    chk("mem_we", mem_we, m_phase == 1 && m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
    if (mem_we) we_cycles++;
    if ((ack0 || ack1) && m_we) wr_acks++;
  end

  task automatic wait_ack(input int port, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!(port ? ack1 : ack0) && cnt < 20);
    chk("ack_timeout", port ? ack1 : ack0, 1);
  endtask

  task automatic wait_any(output int port, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!(ack0 || ack1) && cnt < 20);
    chk("any_ack_timeout", ack0 | ack1, 1);
    port = ack1 ? 1 : 0;
  endtask

  initial begin
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rdata1", rdata1, 0);
    reset = 0;
    // single read
    @(negedge clk); req0 = 1; addr0 = 8'h85;
    @(negedge clk);
    chk("rd_mem_addr", mem_addr, 8'h85);
    wait_ack(0, n);
    chk("rd_latency", n, 1);
    chk("rd_rdata0", rdata0, 8'h3C);
    chk("rd_no_ack1", ack1, 0);
    req0 = 0;
    // single write
    @(negedge clk); req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hA5;
    @(negedge clk);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    chk("wr_mem_we", mem_we, 1);
    wait_ack(1, n);
    chk("wr_latency", n, 1);
    chk("wr_we_count", we_cycles, 1);
    chk("wr_rdata1_kept", rdata1, 0);
    chk("wr_mem_content", mem[8'h10], 8'hA5);
    req1 = 0; we1 = 0;
    // contention after reset
    reset = 1;
    @(negedge clk); reset = 0; req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h02;
    lastc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_any(p, n);
      chk("cont_order", p, i % 2);
      if (i > 0) chk("cont_gap", cyc - lastc, 3);
      lastc = cyc;
    end
    req0 = 0; req1 = 0;
    // lock override, then lock release
    @(negedge clk); req0 = 1; lock0 = 1; req1 = 1;
    wait_any(p, n); chk("lock_first", p, 0); lock0 = 0;
    wait_any(p, n); chk("lock_second", p, 0);
    wait_any(p, n); chk("lock_third", p, 1);
    req0 = 0; req1 = 0;
    @(negedge clk); req0 = 1; lock0 = 1;
    wait_ack(0, n);
    req0 = 0; lock0 = 0;
    repeat (2) @(negedge clk);
    req0 = 1; req1 = 1;
    wait_any(p, n); chk("lock_release", p, 1); req1 = 0;
    wait_any(p, n); chk("release_next", p, 0); req0 = 0;
    // reset during the bus cycle of a write
    @(negedge clk); req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h5A;
    @(posedge clk); #2;
    chk("abort_we_before", mem_we, 1);
    reset = 1; #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_ack1", ack1, 0);
    chk("abort_ack0", ack0, 0);
    @(negedge clk); reset = 0;
    wait_ack(1, n);
    chk("post_rst_latency", n, 2);
    chk("post_rst_mem", mem[8'h20], 8'h5A);
    req1 = 0; we1 = 0;
    repeat (3) @(negedge clk);
    chk("we_total", we_cycles, 2);
    chk("we_vs_write_acks", we_cycles, wr_acks);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
